// File: rtl/aui_am_lock.sv
// aui_am_lock: alignment-marker lock for one lane of the AUI generator/checker
// path. Words are forwarded with one cycle of latency while an FSM
// (SEARCH -> VERIFY -> LOCKED) tracks marker spacing against AM_PERIOD.
// Optional build macro AUI_AM_LOCK_ERR_CNT_EN adds a 16-bit saturating
// marker-error counter on o_am_err.
module aui_am_lock #(
    parameter int LANE_WIDTH = 1360,
    parameter int AM_PERIOD  = 16,
    parameter int LOCK_CNT   = 2,
    parameter int UNLOCK_CNT = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [LANE_WIDTH-1:0] i_lane,
    input  logic                  i_valid,
    input  logic                  sync_lane,
    output logic [LANE_WIDTH-1:0] o_lane,
    output logic                  o_valid,
    output logic                  o_sync,
    output logic                  o_lock,
    output logic                  o_slip
`ifdef AUI_AM_LOCK_ERR_CNT_EN
    ,
    output logic [15:0]           o_am_err
`endif
);

    // pos must be able to hold AM_PERIOD itself (its saturation value)
    localparam int PW = $clog2(AM_PERIOD + 1);
    localparam logic [PW-1:0] POS_LAST = PW'(AM_PERIOD - 1);
    localparam logic [PW-1:0] POS_MAX  = PW'(AM_PERIOD);
    localparam logic [3:0]    LOCK_N   = 4'(LOCK_CNT);
    localparam logic [3:0]    UNLOCK_N = 4'(UNLOCK_CNT);

    typedef enum logic [1:0] {
        SEARCH,
        VERIFY,
        LOCKED
    } state_t;

    state_t         state;
    logic [PW-1:0]  pos;
    logic [3:0]     good;
    logic [3:0]     bad;

    logic           at_exp;
    logic [PW-1:0]  pos_inc;
    logic [3:0]     good_nxt;
    logic [3:0]     bad_nxt;

    assign at_exp   = (pos == POS_LAST);
    assign pos_inc  = (pos == POS_MAX) ? pos : pos + 1'b1;
    assign good_nxt = good + 4'd1;
    assign bad_nxt  = bad + 4'd1;

    // Data path: one-cycle registered copy of the lane, held while invalid
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_lane  <= '0;
            o_valid <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            o_valid <= i_valid;
            if (i_valid) begin
                o_lane <= i_lane;
            end
        end
    end

    // Lock FSM with registered o_sync / o_lock / o_slip
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= SEARCH;
            pos    <= '0;
            good   <= '0;
            bad    <= '0;
            o_sync <= 1'b0;
            o_lock <= 1'b0;
            o_slip <= 1'b0;
        end else begin
            // NOTE: pulse outputs default low every cycle; branches below
            // raise them only for the single word that causes the event.
            o_sync <= 1'b0;
            o_slip <= 1'b0;
            if (i_valid) begin
                pos <= pos_inc;
                case (state)
                    SEARCH: begin
                        if (sync_lane) begin
                            pos  <= '0;
                            good <= 4'd1;
                            if (LOCK_CNT == 1) begin
                                state  <= LOCKED;
                                bad    <= '0;
                                o_lock <= 1'b1;
                                o_sync <= 1'b1;
                            end else begin
                                state <= VERIFY;
                            end
                        end
                    end
                    VERIFY: begin
                        if (sync_lane && at_exp) begin
                            pos  <= '0;
                            good <= good_nxt;
                            if (good_nxt == LOCK_N) begin
                                state  <= LOCKED;
                                bad    <= '0;
                                o_lock <= 1'b1;
                                o_sync <= 1'b1;
                            end
                        end else if (sync_lane) begin
                            pos  <= '0;
                            good <= 4'd1;
                        end else if (at_exp) begin
                            state <= SEARCH;
                        end
                    end
                    LOCKED: begin
                        // Off-slot markers fall through and only advance pos
                        if (at_exp) begin
                            pos <= '0;
                            if (sync_lane) begin
                                bad    <= '0;
                                o_sync <= 1'b1;
                            end else begin
                                bad <= bad_nxt;
                                if (bad_nxt == UNLOCK_N) begin
                                    state  <= SEARCH;
                                    o_lock <= 1'b0;
                                    o_slip <= 1'b1;
                                end
                            end
                        end
                    end
                    default: begin
                        state  <= SEARCH;
                        o_lock <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef AUI_AM_LOCK_ERR_CNT_EN
    // While locked, a slot/marker disagreement is either a missing or a stray marker
    logic err_event;
    assign err_event = i_valid && (state == LOCKED) && (at_exp != sync_lane);

    // Saturating marker-error counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_am_err <= '0;
        end else if (err_event && (o_am_err != 16'hFFFF)) begin
            o_am_err <= o_am_err + 16'd1;
        end
    end
`endif

endmodule
